ex_alu_stage: RTL and testbench
===============================

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the operand and result width.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an operation is presented this cycle.
REQ-005 in_ready  output  1  the stage accepts the operation this cycle.
REQ-006 in_op  input  4  operation code, per REQ-014.
REQ-007 in_a, in_b  input  n  source operands.
REQ-008 out_valid  output  1  a registered result is held.
REQ-009 out_ready  input  1  the consumer takes the result this cycle.
REQ-010 out_result  output  n  the registered result.
REQ-011 out_ovf  output  1  signed overflow on the held ADD or SUB result.
REQ-012 out_illegal  output  1  the held op was reserved code 15.
REQ-013 ovf_sticky  output  1  sticky overflow status; clr_sticky  input  1  clears it.

Function
REQ-014 Op codes SHALL be: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 SEQ, 8 SNE, 9 SLT, 10 SGT, 11 SLE, 12 SGE, 13 LHI, 14 PASSB, 15 reserved.
REQ-015 The decode SHALL drive the ALU as follows:
- ADD/ADDU: s=9, m=1, cin=0.
- SUB/SUBU and all set ops: s=6, m=1, cin=1.
- AND: s=14, m=0.
- OR: s=11, m=0.
- XOR: s=9, m=0.
- PASSB: s=10, m=0.
- LHI: s=10, m=0, with the ALU b input set to {in_b[15:0], 16'b0}.
REQ-016 SEQ and SNE SHALL test for a zero difference; SLT/SGT/SLE/SGE SHALL use signed less-than = diff[n-1] XOR ALU overflow, and equality = zero difference. The result SHALL be 1 or 0, zero-extended to n bits.
REQ-017 out_ovf SHALL equal the ALU overflow for ADD and SUB only, and 0 for every other op, including ADDU and SUBU.
REQ-018 Reserved op 15 SHALL register result 0, out_illegal=1, out_ovf=0.
REQ-019 A transfer SHALL occur when in_valid and in_ready are both 1. The result registers load on the next edge, giving latency 1.
REQ-020 in_ready SHALL be !out_valid || out_ready, a combinational pass-through that allows simultaneous unload and load with no bubble.
REQ-021 out_valid SHALL set on a transfer, clear on out_ready with no transfer, and stay 1 on simultaneous out_ready and transfer.
REQ-022 While out_valid=1 and out_ready=0, out_result, out_ovf and out_illegal SHALL hold stable; input changes SHALL be ignored.
REQ-023 ovf_sticky SHALL set on the edge at which a result with out_ovf=1 is accepted (out_valid && out_ready). clr_sticky SHALL clear it.
REQ-024 If clr_sticky and a set event occur in the same cycle, set SHALL win.
REQ-025 Arithmetic SHALL be modulo 2^n. The ALU carry-out SHALL be discarded.

Reset
REQ-026 While reset=1 the outputs SHALL be: out_valid=0, out_result=0, out_ovf=0, out_illegal=0, ovf_sticky=0.
REQ-027 in_ready SHALL be 0 during reset.
REQ-028 Reset mid-operation SHALL discard any held result. The first transfer SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-029 Op-code constants and the s/m/cin decode table SHALL live in a shared DLX ALU package used by decode and execute.
REQ-030 The block SHALL instantiate exactly one sub-module, the team's alu_generic with n passed through; all other logic SHALL be local.

Verification
REQ-031 After reset, present ADD with a=32'h7FFFFFFF, b=1, and hold out_ready=1.
- Expected: next cycle out_result=32'h80000000, out_ovf=1.
- Expected: ovf_sticky=1 one cycle later.
REQ-032 Present ADDU with a=32'hFFFFFFFF, b=1.
- Expected: out_result=0, out_ovf=0.
REQ-033 SLT with a=32'h80000000, b=1 -> result 1. SGT with the same operands -> 0. SEQ with a=b=5 -> 1. LHI with b=16'h1234 -> 32'h12340000.
REQ-034 Backpressure:
- Stimulus: out_ready=0 for 3 cycles after a SUB 10-3.
- Expected: in_ready=0 and out_result=7 held throughout.
- Stimulus: raise out_ready alongside a new valid op.
- Expected: the next result appears in the following cycle with no bubble.
REQ-035 Illegal op and sticky clear:
- Stimulus: op 15.
- Expected: out_result=0, out_illegal=1.
- Stimulus: clr_sticky during an overflow acceptance.
- Expected: ovf_sticky remains 1.
REQ-036 Mid-operation reset:
- Stimulus: assert reset while out_valid=1.
- Expected: next cycle out_valid=0, in_ready=0.
- Expected: after deassert, a transfer is accepted at once.

Source files
------------

// File: rtl/ex_alu_stage_pkg.sv
// Shared DLX ALU definitions: op codes, ALU function selects and the op -> s/m/cin decode.
package ex_alu_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDU  = 4'd1,
    OP_SUB   = 4'd2,
    OP_SUBU  = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_SEQ   = 4'd7,
    OP_SNE   = 4'd8,
    OP_SLT   = 4'd9,
    OP_SGT   = 4'd10,
    OP_SLE   = 4'd11,
    OP_SGE   = 4'd12,
    OP_LHI   = 4'd13,
    OP_PASSB = 4'd14,
    OP_RSV   = 4'd15
  } op_e;

  localparam logic [3:0] S_ADD   = 4'd9;
  localparam logic [3:0] S_SUB   = 4'd6;
  localparam logic [3:0] S_AND   = 4'd14;
  localparam logic [3:0] S_OR    = 4'd11;
  localparam logic [3:0] S_XOR   = 4'd9;
  localparam logic [3:0] S_PASSB = 4'd10;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
  } alu_ctl_t;

  function automatic alu_ctl_t alu_decode(op_e op);
    alu_ctl_t c;
    c = '{s: S_PASSB, m: 1'b0, cin: 1'b0};
    case (op)
      OP_ADD, OP_ADDU:                         c = '{s: S_ADD, m: 1'b1, cin: 1'b0};
      OP_SUB, OP_SUBU, OP_SEQ, OP_SNE,
      OP_SLT, OP_SGT, OP_SLE, OP_SGE:          c = '{s: S_SUB, m: 1'b1, cin: 1'b1};
      OP_AND:                                  c = '{s: S_AND, m: 1'b0, cin: 1'b0};
      OP_OR:                                   c = '{s: S_OR,  m: 1'b0, cin: 1'b0};
      OP_XOR:                                  c = '{s: S_XOR, m: 1'b0, cin: 1'b0};
      default:                                 c = '{s: S_PASSB, m: 1'b0, cin: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// Operation/result handshake bundle for the EX ALU stage.
interface ex_alu_stage_if #(parameter int n = 32);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_result;
  logic         out_ovf;
  logic         out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_illegal
  );
endinterface

// File: rtl/ex_alu_stage_alu.sv
// alu_generic: function-select ALU (s/m/cin); m=1 arithmetic, m=0 bitwise. Carry-out is not produced.
module alu_generic
  import ex_alu_stage_pkg::*;
#(parameter int n = 32) (
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] f,
  output logic         ovf
);
  logic [n-1:0] bb, sum;
  logic         arith;

  always_comb begin
    bb    = (s == S_SUB) ? ~b : b;
    sum   = a + bb + {{(n-1){1'b0}}, cin};
    arith = (s == S_ADD) || (s == S_SUB);
    f     = '0;
    ovf   = 1'b0;
    if (m) begin
      f   = arith ? sum : a;
      // Same-sign operands producing an opposite-sign sum
      ovf = arith && (a[n-1] == bb[n-1]) && (sum[n-1] != a[n-1]);
    end else begin
      case (s)
        S_AND:   f = a & b;
        S_OR:    f = a | b;
        S_XOR:   f = a ^ b;
        S_PASSB: f = b;
        default: f = '0;
      endcase
    end
  end
endmodule

// File: rtl/ex_alu_stage.sv
// EX stage: decode op, run alu_generic, register result behind a 1-deep valid/ready slot.
module ex_alu_stage
  import ex_alu_stage_pkg::*;
#(parameter int n = 32) (
  input  logic           clk,
  input  logic           reset,
  ex_alu_stage_if.slave  io,
  input  logic           clr_sticky,
  output logic           ovf_sticky
);
  typedef struct packed {
    logic [n-1:0] result;
    logic         ovf;
    logic         ill;
  } res_t;

  op_e          op;
  alu_ctl_t     ctl;
  logic [n-1:0] alu_b, alu_f;
  logic         alu_ovf, lt, eq, bit_r;
  res_t         nxt, held;
  logic         vld, sticky, xfer;

  assign op = op_e'(io.in_op);

  always_comb begin
    ctl   = alu_decode(op);
    alu_b = (op == OP_LHI) ? {io.in_b[15:0], {(n-16){1'b0}}} : io.in_b;
  end

  alu_generic #(.n(n)) u_alu (
    .s(ctl.s), .m(ctl.m), .cin(ctl.cin),
    .a(io.in_a), .b(alu_b), .f(alu_f), .ovf(alu_ovf)
  );

  always_comb begin
    // Set ops see a - b on alu_f; signed lt corrects the sign bit by overflow
    lt    = alu_f[n-1] ^ alu_ovf;
    eq    = (alu_f == '0);
    bit_r = 1'b0;
    nxt   = '{result: alu_f, ovf: 1'b0, ill: 1'b0};
    case (op)
      OP_ADD, OP_SUB: nxt.ovf = alu_ovf;
      OP_SEQ:         bit_r = eq;
      OP_SNE:         bit_r = !eq;
      OP_SLT:         bit_r = lt;
      OP_SGT:         bit_r = !lt && !eq;
      OP_SLE:         bit_r = lt || eq;
      OP_SGE:         bit_r = !lt;
      OP_RSV:         nxt = '{result: '0, ovf: 1'b0, ill: 1'b1};
      default:        ;
    endcase
    if (op inside {OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE})
      nxt.result = {{(n-1){1'b0}}, bit_r};
  end

  assign io.in_ready = !reset && (!vld || io.out_ready);
  assign xfer        = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld    <= 1'b0;
      held   <= '0;
      sticky <= 1'b0;
    end else begin
      if (xfer) begin
        vld  <= 1'b1;
        held <= nxt;
      end else if (io.out_ready) begin
        vld  <= 1'b0;
      end
      if (vld && io.out_ready && held.ovf) sticky <= 1'b1;
      else if (clr_sticky)                 sticky <= 1'b0;
    end
  end

  assign io.out_valid   = vld;
  assign io.out_result  = held.result;
  assign io.out_ovf     = held.ovf;
  assign io.out_illegal = held.ill;
  assign ovf_sticky     = sticky;
endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus randomized traffic vs a behavioural model.
module tb_ex_alu_stage;
  logic clk = 1'b0;
  logic reset, clr_sticky, ovf_sticky;
  int   errors = 0;
  int   checks = 0;

  ex_alu_stage_if #(.n(32)) bus ();

  ex_alu_stage #(.n(32)) dut (
    .clk(clk), .reset(reset), .io(bus.slave),
    .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns {illegal, ovf, result} from the op definitions using signed integer arithmetic
  function automatic logic [33:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, r;
    logic [31:0] res;
    logic ovf, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0; ill = 1'b0; res = 32'd0;
    case (op)
      4'd0:  begin r = sa + sb; res = a + b; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd1:  res = a + b;
      4'd2:  begin r = sa - sb; res = a - b; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd3:  res = a - b;
      4'd4:  res = a & b;
      4'd5:  res = a | b;
      4'd6:  res = a ^ b;
      4'd7:  res = {31'd0, a == b};
      4'd8:  res = {31'd0, a != b};
      4'd9:  res = {31'd0, sa <  sb};
      4'd10: res = {31'd0, sa >  sb};
      4'd11: res = {31'd0, sa <= sb};
      4'd12: res = {31'd0, sa >= sb};
      4'd13: res = b << 16;
      4'd14: res = b;
      default: ill = 1'b1;
    endcase
    return {ill, ovf, res};
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v; bus.in_op = op; bus.in_a = a; bus.in_b = b;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.out_ready = 1'b1; drive(1'b1, 4'd0, 32'd1, 32'd2);
    tick; tick;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.out_result); end
    checks++; if ({bus.out_ovf, bus.out_illegal, ovf_sticky} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {bus.out_ovf, bus.out_illegal, ovf_sticky}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b0;
  endtask

  task automatic test_add_ovf;
    bus.out_ready = 1'b1; drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL first_ready got=%b exp=1", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result got=%h exp=80000000", bus.out_result); end
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL add_ovf got=%b exp=1", bus.out_ovf); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_early got=%b exp=0", ovf_sticky); end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", ovf_sticky); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_directed;
    logic [3:0]  ops [5] = '{4'd1, 4'd9, 4'd10, 4'd7, 4'd13};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hDEAD_BEEF};
    logic [31:0] bs  [5] = '{32'd1, 32'd1, 32'd1, 32'd5, 32'hABCD_1234};
    logic [31:0] exr [5] = '{32'd0, 32'd1, 32'd0, 32'd1, 32'h1234_0000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      tick;
      checks++; if (bus.out_result !== exr[i] || bus.out_ovf !== 1'b0 || bus.out_valid !== 1'b1)
        begin errors++; $display("FAIL directed%0d op=%0d got=%h/%b/%b exp=%h/0/1", i, ops[i], bus.out_result, bus.out_ovf, bus.out_valid, exr[i]); end
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b1; drive(1'b1, 4'd2, 32'd10, 32'd3);
    tick;
    bus.out_ready = 1'b0; drive(1'b1, 4'd6, 32'h55, 32'hAA);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'd7 || bus.out_valid !== 1'b1)
        begin errors++; $display("FAIL bp_hold%0d got=rdy%b res=%h vld%b exp=rdy0 res=7 vld1", i, bus.in_ready, bus.out_result, bus.out_valid); end
      tick;
    end
    bus.out_ready = 1'b1; drive(1'b1, 4'd0, 32'd2, 32'd3);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5)
      begin errors++; $display("FAIL bp_nobubble got=vld%b res=%h exp=vld1 res=5", bus.out_valid, bus.out_result); end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick;
  endtask

  task automatic test_illegal_sticky;
    bus.out_ready = 1'b1; drive(1'b1, 4'd15, 32'h1234, 32'h5678);
    tick;
    checks++; if (bus.out_result !== 32'd0 || bus.out_illegal !== 1'b1 || bus.out_ovf !== 1'b0)
      begin errors++; $display("FAIL illegal got=%h/ill%b/ovf%b exp=0/ill1/ovf0", bus.out_result, bus.out_illegal, bus.out_ovf); end
    drive(1'b0, 4'd0, 32'd0, 32'd0); clr_sticky = 1'b1;
    tick;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr got=%b exp=0", ovf_sticky); end
    clr_sticky = 1'b0; drive(1'b1, 4'd2, 32'h8000_0000, 32'd1);
    tick;
    drive(1'b0, 4'd0, 32'd0, 32'd0); clr_sticky = 1'b1;
    checks++; if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf got=%b exp=1", bus.out_ovf); end
    tick;
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got=%b exp=1", ovf_sticky); end
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b1; drive(1'b1, 4'd14, 32'd0, 32'hCAFE);
    tick;
    bus.out_ready = 1'b0; drive(1'b0, 4'd0, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got=%b exp=0", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || ovf_sticky !== 1'b0)
      begin errors++; $display("FAIL mrst_clear got=vld%b rdy%b st%b exp=000", bus.out_valid, bus.in_ready, ovf_sticky); end
    reset = 1'b0; bus.out_ready = 1'b1; drive(1'b1, 4'd5, 32'hF0, 32'h0F);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_accept got=%b exp=1", bus.in_ready); end
    tick;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFF)
      begin errors++; $display("FAIL mrst_result got=vld%b res=%h exp=vld1 res=ff", bus.out_valid, bus.out_result); end
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick;
  endtask

  task automatic test_random;
    logic        ev, es;
    logic [33:0] eh, m;
    logic        xfer, er;
    ev = bus.out_valid; es = ovf_sticky;
    eh = {bus.out_illegal, bus.out_ovf, bus.out_result};
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + $urandom_range(0, 2) : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      clr_sticky    = $urandom_range(0, 7) == 0;
      #1;
      er = !ev || bus.out_ready;
      checks++; if (bus.in_ready !== er) begin errors++; $display("FAIL rnd_ready%0d got=%b exp=%b", i, bus.in_ready, er); end
      xfer = bus.in_valid && er;
      m    = model(bus.in_op, bus.in_a, bus.in_b);
      if (ev && bus.out_ready && eh[32]) es = 1'b1;
      else if (clr_sticky)              es = 1'b0;
      if (xfer) begin ev = 1'b1; eh = m; end
      else if (bus.out_ready) ev = 1'b0;
      tick;
      checks++; if (bus.out_valid !== ev || ovf_sticky !== es || {bus.out_illegal, bus.out_ovf, bus.out_result} !== eh)
        begin errors++; $display("FAIL rnd_out%0d got=vld%b st%b %h exp=vld%b st%b %h", i, bus.out_valid, ovf_sticky,
                                 {bus.out_illegal, bus.out_ovf, bus.out_result}, ev, es, eh); end
    end
    clr_sticky = 1'b0; drive(1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; clr_sticky = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    test_reset;
    test_add_ovf;
    test_directed;
    test_backpressure;
    test_illegal_sticky;
    test_mid_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
